// File: rtl/adc_status_monitor.sv
// adc_status_monitor: per-channel saturation flags/counters and windowed peak |sample| readout.
// Optional STATUS_HEX_EN adds hex_sel/hex_out, a 4-digit active-low 7-segment view of one channel's peak.
module adc_status_monitor #(
  parameter int N_CH        = 4,
  parameter int DATA_W      = 16,
  parameter int CNT_W       = 16,
  parameter int STRETCH_CYC = 5_000_000,
  parameter int WIN_CYC     = 50_000_000
`ifdef STATUS_HEX_EN
  ,
  localparam int HEX_SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_CH*DATA_W-1:0]   adc_data,
  input  logic                     adc_valid,
  input  logic                     clear,
  output logic [N_CH-1:0]          sat_led,
  output logic                     sat_any,
  output logic [N_CH*CNT_W-1:0]    sat_count,
  output logic [N_CH*DATA_W-1:0]   peak_abs,
  output logic                     peak_valid
`ifdef STATUS_HEX_EN
  ,
  input  logic [HEX_SEL_W-1:0]     hex_sel,
  output logic [27:0]              hex_out
`endif
);

  localparam int STR_W = $clog2(STRETCH_CYC + 1);
  localparam int WIN_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam logic [DATA_W-1:0] S_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] S_MIN    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [STR_W-1:0]  STR_LOAD = STR_W'(STRETCH_CYC);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_CYC - 1);

  logic [DATA_W-1:0] samp      [N_CH];
  logic [DATA_W-1:0] mag       [N_CH];
  logic [DATA_W-1:0] cand      [N_CH];
  logic [N_CH-1:0]   sat_hit;

  logic [STR_W-1:0]  stretch_q [N_CH];
  logic [STR_W-1:0]  stretch_d [N_CH];
  logic [CNT_W-1:0]  cnt_q     [N_CH];
  logic [CNT_W-1:0]  cnt_d     [N_CH];
  logic [DATA_W-1:0] run_q     [N_CH];
  logic [DATA_W-1:0] run_d     [N_CH];
  logic [DATA_W-1:0] peak_q    [N_CH];
  logic [DATA_W-1:0] peak_d    [N_CH];

  logic [N_CH-1:0]   led_q, led_d;
  logic              any_q, any_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              pv_q, pv_d;
  logic              win_last;

  always_comb begin
    win_last = (win_q == WIN_LAST);
    if (clear || win_last) win_d = '0;
    else                   win_d = win_q + 1'b1;
    pv_d = win_last && !clear;

    for (int i = 0; i < N_CH; i++) begin
      samp[i]    = adc_data[i*DATA_W +: DATA_W];
      sat_hit[i] = adc_valid && ((samp[i] == S_MAX) || (samp[i] == S_MIN));
      // The most negative code has no positive twin, so it folds onto full scale.
      if (samp[i] == S_MIN)         mag[i] = S_MAX;
      else if (samp[i][DATA_W-1])   mag[i] = -samp[i];
      else                          mag[i] = samp[i];
      cand[i] = (adc_valid && (mag[i] > run_q[i])) ? mag[i] : run_q[i];

      stretch_d[i] = stretch_q[i];
      cnt_d[i]     = cnt_q[i];
      run_d[i]     = run_q[i];
      peak_d[i]    = peak_q[i];

      if (clear) begin
        stretch_d[i] = '0;
        cnt_d[i]     = '0;
        run_d[i]     = '0;
        peak_d[i]    = '0;
      end else begin
        if (sat_hit[i])               stretch_d[i] = STR_LOAD;
        else if (stretch_q[i] != '0)  stretch_d[i] = stretch_q[i] - 1'b1;

        if (sat_hit[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + 1'b1;

        if (win_last) begin
          peak_d[i] = cand[i];
          run_d[i]  = '0;
        end else begin
          run_d[i]  = cand[i];
        end
      end
    end

    led_d = '0;
    for (int i = 0; i < N_CH; i++) led_d[i] = (stretch_d[i] != '0);
    any_d = |led_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        stretch_q[i] <= '0;
        cnt_q[i]     <= '0;
        run_q[i]     <= '0;
        peak_q[i]    <= '0;
      end
      led_q <= '0;
      any_q <= 1'b0;
      win_q <= '0;
      pv_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        stretch_q[i] <= stretch_d[i];
        cnt_q[i]     <= cnt_d[i];
        run_q[i]     <= run_d[i];
        peak_q[i]    <= peak_d[i];
      end
      led_q <= led_d;
      any_q <= any_d;
      win_q <= win_d;
      pv_q  <= pv_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign sat_count[g*CNT_W +: CNT_W]  = cnt_q[g];
    assign peak_abs[g*DATA_W +: DATA_W] = peak_q[g];
  end

  assign sat_led    = led_q;
  assign sat_any    = any_q;
  assign peak_valid = pv_q;

`ifdef STATUS_HEX_EN
  localparam int HEX_SHIFT = (DATA_W > 16) ? DATA_W - 16 : 0;

  logic [15:0] hex_word;
  logic        hex_dash;
  logic [27:0] hex_d, hex_q;

  // Segment order gfedcba, active-low.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    hex_word = '0;
    hex_dash = (32'(hex_sel) >= 32'(N_CH));
    for (int i = 0; i < N_CH; i++)
      if (hex_sel == HEX_SEL_W'(i)) hex_word = 16'(peak_q[i] >> HEX_SHIFT);
    hex_d = '1;
    for (int k = 0; k < 4; k++)
      hex_d[7*k +: 7] = hex_dash ? 7'h3F : seg7(hex_word[4*k +: 4]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hex_q <= 28'h7FF_FFFF;
    else          hex_q <= hex_d;
  end

  assign hex_out = hex_q;
`endif

endmodule

// File: tb/tb_adc_status_monitor.sv
// Randomised and directed checks of adc_status_monitor against a cycle-indexed event model.
module tb_adc_status_monitor;
  localparam int N_CH = 4, DATA_W = 16, CNT_W = 4, STRETCH_CYC = 8, WIN_CYC = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  sat_led;
  logic        sat_any;
  logic [15:0] sat_count;
  logic [63:0] peak_abs;
  logic        peak_valid;
`ifdef STATUS_HEX_EN
  logic [1:0]  hex_sel = 2'd0;
  logic [27:0] hex_out;
`endif

  always #5 clk = ~clk;

  adc_status_monitor #(
    .N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W),
    .STRETCH_CYC(STRETCH_CYC), .WIN_CYC(WIN_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .clear(clear), .sat_led(sat_led), .sat_any(sat_any), .sat_count(sat_count),
    .peak_abs(peak_abs), .peak_valid(peak_valid)
`ifdef STATUS_HEX_EN
    , .hex_sel(hex_sel), .hex_out(hex_out)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: events indexed by clock edge number since reset release.
  int cyc, w0;
  int last_sat [4];
  int scount   [4];
  int peak_m   [4];
  int win_mags [4][$];
  bit pv_m;

  logic [3:0]  exp_led;
  logic        exp_any;
  logic [15:0] exp_count;
  logic [63:0] exp_peak;
  logic        exp_pv;

  task automatic model_reset();
    cyc = 0; w0 = 0; pv_m = 0;
    for (int ch = 0; ch < 4; ch++) begin
      last_sat[ch] = -1000; scount[ch] = 0; peak_m[ch] = 0; win_mags[ch].delete();
    end
    exp_led = '0; exp_any = 0; exp_count = '0; exp_peak = '0; exp_pv = 0;
  endtask

  task automatic model_step(input logic [63:0] d, input logic v, input logic c);
    int x, a, mx;
    if (c) begin
      for (int ch = 0; ch < 4; ch++) begin
        last_sat[ch] = -1000; scount[ch] = 0; peak_m[ch] = 0; win_mags[ch].delete();
      end
      pv_m = 0;
      w0 = cyc + 1;
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        if (v) begin
          x = int'($signed(d[ch*16 +: 16]));
          if (x == 32767 || x == -32768) begin
            last_sat[ch] = cyc;
            if (scount[ch] < 15) scount[ch]++;
          end
          a = (x < 0) ? -x : x;
          if (a > 32767) a = 32767;
          win_mags[ch].push_back(a);
        end
      end
      pv_m = ((cyc - w0) % WIN_CYC) == WIN_CYC - 1;
      if (pv_m) begin
        for (int ch = 0; ch < 4; ch++) begin
          mx = 0;
          foreach (win_mags[ch][k]) if (win_mags[ch][k] > mx) mx = win_mags[ch][k];
          peak_m[ch] = mx;
          win_mags[ch].delete();
        end
      end
    end
    for (int ch = 0; ch < 4; ch++) begin
      exp_led[ch] = (cyc - last_sat[ch]) < STRETCH_CYC;
      exp_count[ch*4 +: 4] = 4'(scount[ch]);
      exp_peak[ch*16 +: 16] = 16'(peak_m[ch]);
    end
    exp_any = |exp_led;
    exp_pv = pv_m;
    cyc++;
  endtask

  task automatic drive(input logic [63:0] d, input logic v, input logic c);
    adc_data = d; adc_valid = v; clear = c;
    @(posedge clk); #1;
    model_step(d, v, c);
  endtask

  function automatic logic [63:0] small_rand();
    logic [63:0] r;
    for (int ch = 0; ch < 4; ch++) r[ch*16 +: 16] = 16'($urandom_range(0, 1000));
    return r;
  endfunction

  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({sat_led, sat_any, sat_count, peak_abs, peak_valid} !== 86'd0) begin
      n_err++;
      $display("FAIL reset: got led=%b any=%b cnt=%h peak=%h pv=%b, want all zero",
               sat_led, sat_any, sat_count, peak_abs, peak_valid);
    end
    reset_n = 1;
    model_reset();
  endtask

  task automatic test_single_sat();
    int hi = 0;
    logic [63:0] d;
    for (int j = 0; j < 12; j++) begin
      d = small_rand();
      if (j == 0) d[15:0] = 16'h7FFF;
      else        d[15:0] = 16'h0000;
      drive(d, 1'b1, 1'b0);
      if (sat_led[0]) hi++;
      n_vec++;
      if ({sat_led, sat_any, sat_count, peak_abs, peak_valid} !== {exp_led, exp_any, exp_count, exp_peak, exp_pv}) begin
        n_err++;
        $display("FAIL single_sat j=%0d: got led=%b any=%b cnt=%h peak=%h pv=%b want led=%b any=%b cnt=%h peak=%h pv=%b",
                 j, sat_led, sat_any, sat_count, peak_abs, peak_valid, exp_led, exp_any, exp_count, exp_peak, exp_pv);
      end
      if (j == 0) begin
        n_vec++;
        if (sat_count[3:0] !== 4'd1 || sat_led !== 4'b0001) begin
          n_err++;
          $display("FAIL single_sat_first: got cnt0=%h led=%b want 1 0001", sat_count[3:0], sat_led);
        end
      end
    end
    n_vec++;
    if (hi != 8) begin
      n_err++;
      $display("FAIL single_sat_len: got %0d lit cycles want 8", hi);
    end
  endtask

  task automatic test_sat_stick();
    logic [63:0] d;
    for (int j = 0; j < 30; j++) begin
      d = small_rand();
      d[47:32] = (j < 20) ? 16'h8000 : 16'h0000;
      drive(d, 1'b1, 1'b0);
      n_vec++;
      if ({sat_led, sat_any, sat_count, peak_abs, peak_valid} !== {exp_led, exp_any, exp_count, exp_peak, exp_pv}) begin
        n_err++;
        $display("FAIL sat_stick j=%0d: got led=%b any=%b cnt=%h peak=%h pv=%b want led=%b any=%b cnt=%h peak=%h pv=%b",
                 j, sat_led, sat_any, sat_count, peak_abs, peak_valid, exp_led, exp_any, exp_count, exp_peak, exp_pv);
      end
      if (j == 26 || j == 27) begin
        n_vec++;
        if (sat_led[2] !== (j == 26) || sat_count[11:8] !== 4'hF) begin
          n_err++;
          $display("FAIL sat_stick_tail j=%0d: got led2=%b cnt2=%h want %b F", j, sat_led[2], sat_count[11:8], j == 26);
        end
      end
    end
  endtask

  task automatic test_peak_window();
    logic [63:0] d;
    drive(64'd0, 1'b0, 1'b1);
    for (int j = 0; j < 16; j++) begin
      d = small_rand();
      d[31:16] = 16'($urandom_range(0, 40));
      case (j)
        2:  d[31:16] = 16'd100;
        5:  d[31:16] = 16'hF448;
        8:  d[31:16] = 16'h8000;
        11: d[31:16] = 16'd50;
        default: ;
      endcase
      drive(d, 1'b1, 1'b0);
      n_vec++;
      if ({sat_led, sat_any, sat_count, peak_abs, peak_valid} !== {exp_led, exp_any, exp_count, exp_peak, exp_pv}) begin
        n_err++;
        $display("FAIL peak_window j=%0d: got led=%b any=%b cnt=%h peak=%h pv=%b want led=%b any=%b cnt=%h peak=%h pv=%b",
                 j, sat_led, sat_any, sat_count, peak_abs, peak_valid, exp_led, exp_any, exp_count, exp_peak, exp_pv);
      end
    end
    n_vec++;
    if (peak_valid !== 1'b1 || peak_abs[31:16] !== 16'h7FFF) begin
      n_err++;
      $display("FAIL peak_window_ch1: got pv=%b peak1=%h want 1 7fff", peak_valid, peak_abs[31:16]);
    end
  endtask

  task automatic test_terminal();
    logic [63:0] d;
    drive(64'd0, 1'b0, 1'b1);
    for (int j = 0; j < 32; j++) begin
      d = '0;
      if (j == 4)  d[63:48] = 16'd150;
      if (j == 15) d[63:48] = 16'hFF38;
      if (j == 16) d[63:48] = 16'd10;
      drive(d, 1'b1, 1'b0);
      n_vec++;
      if ({sat_led, sat_any, sat_count, peak_abs, peak_valid} !== {exp_led, exp_any, exp_count, exp_peak, exp_pv}) begin
        n_err++;
        $display("FAIL terminal j=%0d: got peak=%h pv=%b want peak=%h pv=%b", j, peak_abs, peak_valid, exp_peak, exp_pv);
      end
      if (j == 15 || j == 31) begin
        n_vec++;
        if (peak_abs[63:48] !== ((j == 15) ? 16'd200 : 16'd10) || peak_valid !== 1'b1) begin
          n_err++;
          $display("FAIL terminal_ch3 j=%0d: got peak3=%0d pv=%b want %0d 1", j, peak_abs[63:48], peak_valid, (j == 15) ? 200 : 10);
        end
      end
    end
  endtask

  task automatic test_clear();
    drive(64'h0000_0000_0000_7FFF, 1'b1, 1'b0);
    drive(64'h0000_0000_0000_7FFF, 1'b1, 1'b1);
    n_vec++;
    if (sat_count !== 16'd0 || sat_led !== 4'd0 || sat_any !== 1'b0 || peak_abs !== 64'd0 || peak_valid !== 1'b0) begin
      n_err++;
      $display("FAIL clear: got cnt=%h led=%b any=%b peak=%h pv=%b want all zero", sat_count, sat_led, sat_any, peak_abs, peak_valid);
    end
    drive(64'd0, 1'b1, 1'b0);
    n_vec++;
    if ({sat_led, sat_any, sat_count, peak_abs, peak_valid} !== {exp_led, exp_any, exp_count, exp_peak, exp_pv} || sat_led[0] !== 1'b0) begin
      n_err++;
      $display("FAIL clear_after: got led=%b cnt=%h peak=%h want led=%b cnt=%h peak=%h", sat_led, sat_count, peak_abs, exp_led, exp_count, exp_peak);
    end
  endtask

  task automatic test_async_reset();
    for (int j = 0; j < 5; j++) drive({16'd300, 16'h8000, 16'd7, 16'h7FFF}, 1'b1, 1'b0);
    @(posedge clk); #3;
    reset_n = 0;
    #1;
    n_vec++;
    if ({sat_led, sat_any, sat_count, peak_abs, peak_valid} !== 86'd0) begin
      n_err++;
      $display("FAIL async_reset: got led=%b cnt=%h peak=%h pv=%b want all zero", sat_led, sat_count, peak_abs, peak_valid);
    end
    @(posedge clk); #1;
    reset_n = 1;
    model_reset();
    for (int j = 0; j < 20; j++) begin
      drive(small_rand(), 1'b1, 1'b0);
      n_vec++;
      if ({sat_led, sat_any, sat_count, peak_abs, peak_valid} !== {exp_led, exp_any, exp_count, exp_peak, exp_pv} || peak_valid !== (j == 15)) begin
        n_err++;
        $display("FAIL async_restart j=%0d: got pv=%b peak=%h want pv=%b peak=%h", j, peak_valid, peak_abs, exp_pv, exp_peak);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] d;
    logic v, c;
    int r;
    for (int j = 0; j < 400; j++) begin
      for (int ch = 0; ch < 4; ch++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      d[ch*16 +: 16] = 16'h7FFF;
        else if (r == 1) d[ch*16 +: 16] = 16'h8000;
        else             d[ch*16 +: 16] = 16'($urandom);
      end
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      drive(d, v, c);
      n_vec++;
      if ({sat_led, sat_any, sat_count, peak_abs, peak_valid} !== {exp_led, exp_any, exp_count, exp_peak, exp_pv}) begin
        n_err++;
        $display("FAIL random j=%0d: got led=%b any=%b cnt=%h peak=%h pv=%b want led=%b any=%b cnt=%h peak=%h pv=%b",
                 j, sat_led, sat_any, sat_count, peak_abs, peak_valid, exp_led, exp_any, exp_count, exp_peak, exp_pv);
      end
    end
  endtask

`ifdef STATUS_HEX_EN
  task automatic test_hex();
    hex_sel = 2'd1;
    drive(64'd0, 1'b0, 1'b1);
    for (int j = 0; j < 16; j++) drive({32'd0, 16'h1A2F, 16'd0}, 1'b1, 1'b0);
    drive(64'd0, 1'b0, 1'b0);
    n_vec++;
    if (hex_out !== {7'h79, 7'h08, 7'h24, 7'h0E}) begin
      n_err++;
      $display("FAIL hex: got %h want %h", hex_out, {7'h79, 7'h08, 7'h24, 7'h0E});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_sat();
    test_sat_stick();
    test_peak_window();
    test_terminal();
    test_clear();
    test_async_reset();
    test_random();
`ifdef STATUS_HEX_EN
    test_hex();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
